// File: rtl/usb_rx_decoder.sv
// USB receive front end: classifies DP/DM line states, checks SYNC, NRZI-decodes,
// strips stuffed bits and detects EOP, delivering the packet as a bit vector.
module usb_rx_decoder #(
  parameter int MAX_BITS = 100
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx_enable,
  input  logic                in_DP,
  input  logic                in_DM,
  output logic [MAX_BITS-1:0] pkt_out,
  output logic [31:0]         pkt_len,
  output logic                pkt_valid,
  output logic                rx_busy,
  output logic                rx_error,
  output logic [1:0]          err_code
);

  typedef enum logic [1:0] {
    SYM_SE0 = 2'd0,
    SYM_K   = 2'd1,
    SYM_J   = 2'd2,
    SYM_SE1 = 2'd3
  } sym_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP1 = 3'd3,
    ST_EOP2 = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6,
    ST_WAIT = 3'd7
  } state_e;

  localparam logic [1:0] ERR_SYNC  = 2'd0;
  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_EOP   = 2'd3;

  state_e     state_r;
  sym_e       prev_sym_r;
  logic [2:0] sync_cnt_r;
  logic [2:0] ones_r;
  logic       wait_se0_r;

  sym_e       sym_s;
  sym_e       sync_exp_s;
  logic       bit_s;
  logic       err_hit_s;
  logic [1:0] err_sel_s;

  // Line-state classification; anything not a clean J/K/SE0 (incl. X/Z) is SE1.
  always_comb begin
    sym_s = SYM_SE1;
    case ({in_DP, in_DM})
      2'b10:   sym_s = SYM_J;
      2'b01:   sym_s = SYM_K;
      2'b00:   sym_s = SYM_SE0;
      default: sym_s = SYM_SE1;
    endcase
    bit_s = (sym_s == prev_sym_r);
    // sync_cnt_r holds the number of SYNC symbols already accepted
    sync_exp_s = (sync_cnt_r[0] && (sync_cnt_r != 3'd7)) ? SYM_J : SYM_K;
  end

  // Receive-error detection for the current sample.
  always_comb begin
    err_hit_s = 1'b0;
    err_sel_s = ERR_SYNC;
    case (state_r)
      ST_SYNC: begin
        err_hit_s = (sym_s != sync_exp_s);
        err_sel_s = ERR_SYNC;
      end
      ST_DATA: begin
        if (sym_s == SYM_SE1) begin
          err_hit_s = 1'b1;
          err_sel_s = ERR_OVF;
        end else if (sym_s == SYM_SE0) begin
          err_hit_s = 1'b0;
          err_sel_s = ERR_SYNC;
        end else if (ones_r == 3'd6) begin
          err_hit_s = bit_s;
          err_sel_s = ERR_STUFF;
        end else begin
          err_hit_s = (pkt_len == 32'(MAX_BITS));
          err_sel_s = ERR_OVF;
        end
      end
      ST_EOP1: begin
        err_hit_s = (sym_s != SYM_SE0);
        err_sel_s = ERR_EOP;
      end
      ST_EOP2: begin
        err_hit_s = (sym_s != SYM_J);
        err_sel_s = ERR_EOP;
      end
      default: begin
        err_hit_s = 1'b0;
        err_sel_s = ERR_SYNC;
      end
    endcase
  end

  // Receive FSM with registered strobes and packet buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      prev_sym_r <= SYM_J;
      sync_cnt_r <= 3'd0;
      ones_r     <= 3'd0;
      wait_se0_r <= 1'b0;
      pkt_out    <= '0;
      pkt_len    <= 32'd0;
      pkt_valid  <= 1'b0;
      rx_busy    <= 1'b0;
      rx_error   <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      pkt_valid <= 1'b0;
      rx_error  <= 1'b0;
      if (!rx_enable) begin
        state_r <= ST_IDLE;
        rx_busy <= 1'b0;
        if (state_r inside {ST_SYNC, ST_DATA, ST_EOP1, ST_EOP2, ST_DONE}) begin
          pkt_out <= '0;
          pkt_len <= 32'd0;
        end
      end else if (err_hit_s) begin
        state_r    <= ST_ERR;
        rx_error   <= 1'b1;
        err_code   <= err_sel_s;
        wait_se0_r <= 1'b0;
        rx_busy    <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (sym_s == SYM_K) begin
              state_r    <= ST_SYNC;
              sync_cnt_r <= 3'd1;
              pkt_out    <= '0;
              pkt_len    <= 32'd0;
              rx_busy    <= 1'b1;
            end
          end
          ST_SYNC: begin
            if (sync_cnt_r == 3'd7) begin
              // trailing KK of SYNC is the first '1' seen by the stuffing counter
              state_r    <= ST_DATA;
              prev_sym_r <= SYM_K;
              ones_r     <= 3'd1;
            end else begin
              sync_cnt_r <= sync_cnt_r + 3'd1;
            end
          end
          ST_DATA: begin
            case (sym_s)
              SYM_SE0: state_r <= ST_EOP1;
              SYM_J, SYM_K: begin
                prev_sym_r <= sym_s;
                if (ones_r == 3'd6) begin
                  ones_r <= 3'd0;
                end else begin
                  pkt_out <= {pkt_out[MAX_BITS-2:0], bit_s};
                  pkt_len <= pkt_len + 32'd1;
                  ones_r  <= bit_s ? (ones_r + 3'd1) : 3'd0;
                end
              end
              default: state_r <= state_r;
            endcase
          end
          ST_EOP1: state_r <= ST_EOP2;
          ST_EOP2: begin
            state_r   <= ST_DONE;
            pkt_valid <= 1'b1;
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
          ST_ERR: state_r <= ST_WAIT;
          ST_WAIT: begin
            wait_se0_r <= (sym_s == SYM_SE0);
            if ((sym_s == SYM_J) && wait_se0_r) begin
              state_r <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
